// File: rtl/mdu_pkg.sv
// Shared MDU definitions: MDUControl encodings, FSM states and cycle defaults.
// The decoder and the multiply/divide unit both use these names.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 8;

    // Ops that run multi-cycle and commit a 64-bit result to HI/LO.
    function automatic logic is_md_op(input mdu_op_e op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
                          MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
    endfunction

    function automatic logic is_div_op(input mdu_op_e op);
        return op inside {MDU_DIV, MDU_DIVU};
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: produces the 64-bit {HI,LO} result for an op,
// plus a keep flag that leaves HI/LO untouched on divide-by-zero.
module mdu_arith
    import mdu_pkg::*;
(
    input  mdu_op_e     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_res,
    output logic        o_keep
);

    logic [63:0] w_acc;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_zero;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_div_bu;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;

    assign w_acc    = {i_hi, i_lo};
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 rem 0.
    // A zero divisor is swapped for 1 to keep the dividers X-free; keep hides the result.
    assign w_div_zero = (i_b == 32'd0);
    assign w_abs_a    = i_a[31] ? -i_a : i_a;
    assign w_abs_b    = w_div_zero ? 32'd1 : (i_b[31] ? -i_b : i_b);
    assign w_div_bu   = w_div_zero ? 32'd1 : i_b;

    assign w_q_mag = w_abs_a / w_abs_b;
    assign w_r_mag = w_abs_a % w_abs_b;
    assign w_q_s   = (i_a[31] ^ i_b[31]) ? -w_q_mag : w_q_mag;
    assign w_r_s   = i_a[31] ? -w_r_mag : w_r_mag;
    assign w_q_u   = i_a / w_div_bu;
    assign w_r_u   = i_a % w_div_bu;

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        o_res  = w_acc;
        o_keep = 1'b0;
        case (i_op)
            MDU_MULT:  o_res = w_prod_s;
            MDU_MULTU: o_res = w_prod_u;
            MDU_MADD:  o_res = w_acc + w_prod_s;
            MDU_MADDU: o_res = w_acc + w_prod_u;
            MDU_MSUB:  o_res = w_acc - w_prod_s;
            MDU_MSUBU: o_res = w_acc - w_prod_u;
            MDU_DIV: begin
                o_res  = {w_r_s, w_q_s};
                o_keep = w_div_zero;
            end
            MDU_DIVU: begin
                o_res  = {w_r_u, w_q_u};
                o_keep = w_div_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: IDLE/BUSY FSM with a down-counter, a pending
// result register committed to HI/LO when the counter expires, and the MFHI/MFLO mux.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    mdu_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [63:0]      r_pend, w_pend_nxt;
    logic             r_keep, w_keep_nxt;
    logic [31:0]      r_hi, w_hi_nxt;
    logic [31:0]      r_lo, w_lo_nxt;

    mdu_op_e          w_op;
    logic [63:0]      w_res;
    logic             w_keep;

    assign w_op = mdu_op_e'(MDUControl);

    mdu_arith u_arith (
        .i_op   (w_op),
        .i_a    (A),
        .i_b    (B),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .o_res  (w_res),
        .o_keep (w_keep)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_keep  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_keep  <= w_keep_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_keep_nxt  = r_keep;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    if (is_md_op(w_op)) begin
                        w_pend_nxt  = w_res;
                        w_keep_nxt  = w_keep;
                        w_cnt_nxt   = is_div_op(w_op) ? CNT_W'(DIV_CYCLES - 1)
                                                      : CNT_W'(MULT_CYCLES - 1);
                        w_state_nxt = ST_BUSY;
                    end else if (w_op == MDU_MTHI) begin
                        w_hi_nxt = A;
                    end else if (w_op == MDU_MTLO) begin
                        w_lo_nxt = A;
                    end
                end
            end
            ST_BUSY: begin
                // Start is ignored here; the hazard unit keeps MDU ops out while busy.
                if (r_cnt == '0) begin
                    if (!r_keep) begin
                        w_hi_nxt = r_pend[63:32];
                        w_lo_nxt = r_pend[31:0];
                    end
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign Busy = (r_state == ST_BUSY);
    assign HI   = r_hi;
    assign LO   = r_lo;

    always_comb begin
        MDUOut = 32'd0;
        if (w_op == MDU_MFHI)
            MDUOut = r_hi;
        else if (w_op == MDU_MFLO)
            MDUOut = r_lo;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: the driver pushes expected HI/LO results and
// MDUOut values from a plain-arithmetic model; a monitor pops and compares them.
module tb_mdu_unit;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    mdu_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .MDUControl (MDUControl),
        .A          (A),
        .B          (B),
        .Busy       (Busy),
        .HI         (HI),
        .LO         (LO),
        .MDUOut     (MDUOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] old_v;
        logic [63:0] new_v;
        int          n;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mfq[$];
    logic [31:0] m_hi, m_lo;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit is_md(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12);
    endfunction

    // Reference model: new {HI,LO} from the architectural rules, using plain integer math.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     acc;
        int              q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        acc = {m_hi, m_lo};
        case (op)
            4'd1:  return sa * sb;
            4'd2:  return ua * ub;
            4'd9:  return acc + (sa * sb);
            4'd10: return acc + (ua * ub);
            4'd11: return acc - (sa * sb);
            4'd12: return acc - (ua * ub);
            4'd3: begin
                if (b == 32'd0) return acc;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            4'd4: begin
                if (b == 32'd0) return acc;
                return {a % b, a / b};
            end
            default: return acc;
        endcase
    endfunction

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!Busy) done = 1'b1;
        end
        check("busy_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit no_wait);
        exp_t e;
        @(posedge clk);
        #1;
        Start      = 1'b1;
        MDUControl = op;
        A          = a;
        B          = b;
        if (is_md(op)) begin
            e.old_v = {m_hi, m_lo};
            e.new_v = model(op, a, b);
            e.n     = (op == 4'd3 || op == 4'd4) ? ND : NM;
            sbq.push_back(e);
            {m_hi, m_lo} = e.new_v;
        end else if (op == 4'd7) begin
            m_hi = a;
        end else if (op == 4'd8) begin
            m_lo = a;
        end else if (op == 4'd5) begin
            mfq.push_back(m_hi);
        end else if (op == 4'd6 || op == 4'd0) begin
            mfq.push_back(op == 4'd6 ? m_lo : 32'd0);
        end
        @(posedge clk);
        #1;
        Start      = 1'b0;
        MDUControl = 4'd0;
        if (is_md(op) && !no_wait) wait_idle();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: compares held/committed HI/LO, busy length and MDUOut against the queues.
    initial begin
        bit   prev = 1'b0;
        int   cnt  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
                cnt  = 0;
            end else begin
                if (Busy) begin
                    cnt++;
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL busy_without_op actual=busy expected=idle");
                    end else begin
                        check("hold_hilo", {HI, LO}, sbq[0].old_v);
                    end
                end else if (prev) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL commit_without_op actual=commit expected=none");
                    end else begin
                        e = sbq.pop_front();
                        check("commit_hilo", {HI, LO}, e.new_v);
                        check("busy_len", 64'(cnt), 64'(e.n));
                    end
                    cnt = 0;
                end
                prev = Busy;
                if (Start && (MDUControl == 4'd0 || MDUControl == 4'd5 || MDUControl == 4'd6)) begin
                    if (mfq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mduout_unexpected actual=%h expected=none", MDUOut);
                    end else begin
                        check("mduout", {32'd0, MDUOut}, {32'd0, mfq.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb;
        reset      = 1'b1;
        Start      = 1'b0;
        MDUControl = 4'd0;
        A          = 32'd0;
        B          = 32'd0;
        m_hi       = 32'd0;
        m_lo       = 32'd0;
        #3;
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        check("reset_mduout", {32'd0, MDUOut}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed cases with hand-computed results.
        drive(4'd1, 32'hFFFF_FFFF, 32'h2, 1'b0);
        check("t1_mult", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
        drive(4'd2, 32'hFFFF_FFFF, 32'h2, 1'b0);
        check("t1_multu", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
        drive(4'd3, 32'hFFFF_FFF9, 32'h2, 1'b0);
        check("t2_div", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        drive(4'd4, 32'd7, 32'd2, 1'b0);
        check("t2_divu", {HI, LO}, 64'h0000_0001_0000_0003);
        drive(4'd7, 32'd5, 32'd0, 1'b0);
        drive(4'd8, 32'd0, 32'd0, 1'b0);
        drive(4'd3, 32'd1234, 32'd0, 1'b0);
        check("t3_div0", {HI, LO}, 64'h0000_0005_0000_0000);
        drive(4'd7, 32'd0, 32'd0, 1'b0);
        drive(4'd8, 32'd10, 32'd0, 1'b0);
        drive(4'd9, 32'd3, 32'd4, 1'b0);
        check("t4_madd", {HI, LO}, 64'h0000_0000_0000_0016);
        drive(4'd12, 32'd1, 32'h17, 1'b0);
        check("t4_msubu", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);
        drive(4'd5, 32'd0, 32'd0, 1'b0);

        // Start during BUSY is ignored; LO ends with the product.
        drive(4'd1, 32'd1000, 32'd3000, 1'b1);
        @(posedge clk);
        #1;
        Start      = 1'b1;
        MDUControl = 4'd8;
        A          = 32'hAA;
        @(posedge clk);
        #1;
        Start      = 1'b0;
        MDUControl = 4'd0;
        wait_idle();
        check("t6_ignore", {32'd0, LO}, 64'd3_000_000);
        drive(4'd6, 32'd0, 32'd0, 1'b0);

        // Reset in the middle of a DIV discards the pending result.
        drive(4'd4, 32'd100, 32'd7, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        sbq.delete();
        reset = 1'b1;
        #1;
        check("t5_reset_busy", {63'd0, Busy}, 64'd0);
        check("t5_reset_hilo", {HI, LO}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (15) @(negedge clk);
        check("t5_no_commit", {HI, LO}, 64'd0);
        check("t5_idle", {63'd0, Busy}, 64'd0);

        // Randomized ops over all encodings, including unknown codes 13-15.
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = rand_operand();
            rb = rand_operand();
            drive(op, ra, rb, 1'b0);
        end
        drive(4'd5, 32'd0, 32'd0, 1'b0);
        drive(4'd6, 32'd0, 32'd0, 1'b0);

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sbq.size() + mfq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
